// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, opcodes,
// funct codes, ALU controls and datapath mux selects. The BNE state exists only with MC_BNE_EN.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQ     = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
`ifdef MC_BNE_EN
        S_JUMP    = 4'd11,
        S_BNE     = 4'd12
`else
        S_JUMP    = 4'd11
`endif
    } mc_state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_OUT  = 2'b01;
    localparam logic [1:0] PCSRC_JUMP = 2'b10;

endpackage

// File: rtl/mips_mc_ctrl_aludec.sv
// ALU decoder: maps the FSM's aluop class plus the R-type funct field onto
// the 4-bit ALU control code.
module mc_aludec
    import mips_mc_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [5:0] funct_i,
    output logic [3:0] alucontrol_o
);

    always_comb begin
        alucontrol_o = ALU_ADD;
        case (aluop_i)
            ALUOP_ADD: alucontrol_o = ALU_ADD;
            ALUOP_SUB: alucontrol_o = ALU_SUB;
            default: begin
                // Unrecognised funct falls back to add; the FSM still writes back.
                case (funct_i)
                    FN_ADD:  alucontrol_o = ALU_ADD;
                    FN_SUB:  alucontrol_o = ALU_SUB;
                    FN_AND:  alucontrol_o = ALU_AND;
                    FN_OR:   alucontrol_o = ALU_OR;
                    FN_SLT:  alucontrol_o = ALU_SLT;
                    default: alucontrol_o = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM (Moore): every datapath enable/select is a decode
// of the state register; pcen also sees zero. Define MC_BNE_EN to add the BNE state.
module mips_mc_ctrl
    import mips_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [3:0] alucontrol,
    output logic [3:0] state
);

    mc_state_e  state_q, state_d;
    logic [1:0] aluop;
    logic       pcwrite, branch, bne;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = S_FETCH;
        aluop    = ALUOP_ADD;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        bne      = 1'b0;
        iord     = 1'b0;
        irwrite  = 1'b0;
        memwrite = 1'b0;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = SRCB_B;
        pcsrc    = PCSRC_ALU;
        case (state_q)
            S_FETCH: begin
                irwrite = 1'b1;
                alusrcb = SRCB_FOUR;
                pcwrite = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is computed speculatively into ALUOut here.
                alusrcb = SRCB_IMMSH;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_BNE_EN
                    OP_BNE:       state_d = S_BNE;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                state_d = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_BEQ: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = PCSRC_OUT;
                branch  = 1'b1;
            end
`ifdef MC_BNE_EN
            S_BNE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = PCSRC_OUT;
                bne     = 1'b1;
            end
`endif
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_JUMP: begin
                pcsrc   = PCSRC_JUMP;
                pcwrite = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    mc_aludec u_aludec (
        .aluop_i      (aluop),
        .funct_i      (funct),
        .alucontrol_o (alucontrol)
    );

    assign pcen  = pcwrite | (branch & zero) | (bne & ~zero);
    assign state = state_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: a per-instruction state-path model plus a per-state
// output table, checked every cycle, with directed literal sequences pinning the model.
module tb_mips_mc_ctrl;

    typedef struct packed {
        logic       pcen;
        logic       iord;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [3:0] alucontrol;
    } outs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       pcen, iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] alucontrol, state;

    int         total = 0;
    int         bad = 0;
    logic       chk_en = 1'b0;
    int         exp_state = 0;
    int         q[$];
    logic [5:0] nxt_op = 6'b111111, nxt_funct = '0;
    logic [5:0] cur_op = 6'b111111, cur_funct = '0;

    logic [3:0] rec_state [0:7];
    logic       rec_pcen [0:7];
    logic       rec_iord [0:7];
    logic       rec_regwrite [0:7];
    logic       rec_memtoreg [0:7];
    logic       rec_memwrite [0:7];
    logic       rec_regdst [0:7];
    logic [1:0] rec_pcsrc [0:7];
    logic [3:0] rec_alu [0:7];

    mips_mc_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .pcen       (pcen),
        .iord       (iord),
        .irwrite    (irwrite),
        .memwrite   (memwrite),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .state      (state)
    );

    always #5 clk = ~clk;

    // States visited after DECODE for a given opcode; empty means straight back to FETCH.
    function automatic void push_path(logic [5:0] o);
        case (o)
            6'b100011: begin q.push_back(2); q.push_back(3); q.push_back(4); end
            6'b101011: begin q.push_back(2); q.push_back(5); end
            6'b000000: begin q.push_back(6); q.push_back(7); end
            6'b000100: q.push_back(8);
            6'b001000: begin q.push_back(9); q.push_back(10); end
            6'b000010: q.push_back(11);
`ifdef MC_BNE_EN
            6'b000101: q.push_back(12);
`endif
            default: ;
        endcase
    endfunction

    function automatic logic [3:0] funct_alu(logic [5:0] f);
        case (f)
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            default:   return 4'b0010;
        endcase
    endfunction

    function automatic logic alu_used(int s);
        return (s == 0 || s == 1 || s == 2 || s == 6 || s == 8 || s == 9 || s == 12);
    endfunction

    function automatic outs_t model_out(int s, logic [5:0] f, logic z);
        outs_t o;
        o = '0;
        case (s)
            0: begin o.irwrite = 1; o.alusrcb = 2'b01; o.alucontrol = 4'b0010; o.pcen = 1; end
            1: begin o.alusrcb = 2'b11; o.alucontrol = 4'b0010; end
            2, 9: begin o.alusrca = 1; o.alusrcb = 2'b10; o.alucontrol = 4'b0010; end
            3: o.iord = 1;
            4: begin o.regwrite = 1; o.memtoreg = 1; end
            5: begin o.iord = 1; o.memwrite = 1; end
            6: begin o.alusrca = 1; o.alucontrol = funct_alu(f); end
            7: begin o.regwrite = 1; o.regdst = 1; end
            8: begin o.alusrca = 1; o.alucontrol = 4'b0110; o.pcsrc = 2'b01; o.pcen = z; end
            10: o.regwrite = 1;
            11: begin o.pcsrc = 2'b10; o.pcen = 1; end
            12: begin o.alusrca = 1; o.alucontrol = 4'b0110; o.pcsrc = 2'b01; o.pcen = ~z; end
            default: ;
        endcase
        return o;
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    // One clock: advance the model at the edge, then drive this cycle's inputs.
    task automatic cycle(input logic rst_v, input logic z_v);
        logic rst_edge;
        @(posedge clk);
        rst_edge = reset;
        #1;
        if (rst_edge) begin
            exp_state = 0;
            q.delete();
        end else if (q.size() > 0) begin
            exp_state = q.pop_front();
        end else begin
            exp_state = 0;
        end
        reset = rst_v;
        zero  = z_v;
        if (exp_state == 0) begin
            cur_op    = nxt_op;
            cur_funct = nxt_funct;
            op        = 6'($urandom);
            funct     = 6'($urandom);
            q.push_back(1);
        end else begin
            op    = cur_op;
            funct = cur_funct;
            if (exp_state == 1) push_path(cur_op);
        end
    endtask

    task automatic record(input int i);
        rec_state[i]    = state;
        rec_pcen[i]     = pcen;
        rec_iord[i]     = iord;
        rec_regwrite[i] = regwrite;
        rec_memtoreg[i] = memtoreg;
        rec_memwrite[i] = memwrite;
        rec_regdst[i]   = regdst;
        rec_pcsrc[i]    = pcsrc;
        rec_alu[i]      = alucontrol;
    endtask

    task automatic wait_state(input int s, input logic z, input string nm);
        int n;
        n = 0;
        cycle(1'b0, z);
        while (exp_state != s && n < 20) begin
            cycle(1'b0, z);
            n++;
        end
        if (n >= 20) chk({nm, " reach-state"}, n, 0);
    endtask

    // Runs one instruction from its FETCH through the next FETCH, checking a literal state trace.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int len, input logic [31:0] seq, input string nm);
        nxt_op    = o;
        nxt_funct = f;
        wait_state(0, z, nm);
        for (int i = 0; i <= len; i++) begin
            if (i > 0) cycle(1'b0, z);
            #4;
            record(i);
            chk({nm, " state"}, int'(state), int'(seq[4*i +: 4]));
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            outs_t e, a;
            e = model_out(exp_state, funct, zero);
            a = {pcen, iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca,
                 alusrcb, pcsrc, alucontrol};
            if (!alu_used(exp_state)) begin
                e.alucontrol = '0;
                a.alucontrol = '0;
            end
            total++;
            if (int'(state) != exp_state) begin
                bad++;
                $display("FAIL model-state: got %0d expected %0d", state, exp_state);
            end
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL model-outputs st=%0d: got %h expected %h", exp_state, a, e);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        chk_en = 1'b1;
        #4;
        chk("reset state", int'(state), 0);
        chk("reset irwrite", int'(irwrite), 1);
        chk("reset pcen", int'(pcen), 1);
        chk("reset alusrcb", int'(alusrcb), 1);
        chk("reset alucontrol", int'(alucontrol), 4'b0010);

        // Reset held three cycles while in MEMRD.
        nxt_op = 6'b100011;
        wait_state(3, 1'b0, "rst-memrd");
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        #4;
        chk("rst-rel state", int'(state), 0);
        chk("rst-rel irwrite", int'(irwrite), 1);
        chk("rst-rel pcen", int'(pcen), 1);
        chk("rst-rel regwrite", int'(regwrite), 0);
        cycle(1'b0, 1'b0);
        #4;
        chk("rst-rel decode", int'(state), 1);

        run_instr(6'b100011, 6'd0, 1'b0, 5, 32'h0004_3210, "lw");
        for (int i = 0; i <= 5; i++) begin
            chk("lw iord", int'(rec_iord[i]), (i == 3) ? 1 : 0);
            chk("lw regwrite", int'(rec_regwrite[i]), (i == 4) ? 1 : 0);
            chk("lw memtoreg", int'(rec_memtoreg[i]), (i == 4) ? 1 : 0);
        end

        run_instr(6'b000000, 6'b101010, 1'b0, 4, 32'h0000_7610, "rtype");
        chk("rtype slt alu", int'(rec_alu[2]), 4'b0111);
        chk("rtype regdst", int'(rec_regdst[3]), 1);
        chk("rtype regwrite", int'(rec_regwrite[3]), 1);

        run_instr(6'b000100, 6'd0, 1'b1, 3, 32'h0000_0810, "beq-z1");
        chk("beq-z1 pcen", int'(rec_pcen[2]), 1);
        chk("beq-z1 pcsrc", int'(rec_pcsrc[2]), 1);
        run_instr(6'b000100, 6'd0, 1'b0, 3, 32'h0000_0810, "beq-z0");
        chk("beq-z0 pcen", int'(rec_pcen[2]), 0);

        run_instr(6'b111111, 6'd0, 1'b1, 2, 32'h0000_0010, "unknown-op");
        chk("unknown pcen decode", int'(rec_pcen[1]), 0);
        for (int i = 0; i <= 2; i++) begin
            chk("unknown regwrite", int'(rec_regwrite[i]), 0);
            chk("unknown memwrite", int'(rec_memwrite[i]), 0);
        end

        run_instr(6'b101011, 6'd0, 1'b0, 4, 32'h0000_5210, "sw");
        run_instr(6'b001000, 6'd0, 1'b0, 4, 32'h0000_A910, "addi");
        run_instr(6'b000010, 6'd0, 1'b0, 3, 32'h0000_0B10, "j");
        chk("j pcen", int'(rec_pcen[2]), 1);
        chk("j pcsrc", int'(rec_pcsrc[2]), 2);

`ifdef MC_BNE_EN
        run_instr(6'b000101, 6'd0, 1'b0, 3, 32'h0000_0C10, "bne");
        chk("bne pcen", int'(rec_pcen[2]), 1);
        chk("bne pcsrc", int'(rec_pcsrc[2]), 1);
`else
        run_instr(6'b000101, 6'd0, 1'b0, 2, 32'h0000_0010, "bne-off");
        chk("bne-off pcen decode", int'(rec_pcen[1]), 0);
`endif

        // Random instruction stream with occasional resets mid-instruction.
        for (int c = 0; c < 3000; c++) begin
            logic [5:0] pick_op [0:7];
            logic [5:0] pick_fn [0:4];
            int         k;
            pick_op = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                        6'b001000, 6'b000010, 6'b000101, 6'b111111};
            pick_fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
            k = $urandom_range(0, 9);
            nxt_op = (k < 8) ? pick_op[k] : 6'($urandom);
            k = $urandom_range(0, 6);
            nxt_funct = (k < 5) ? pick_fn[k] : 6'($urandom);
            if ($urandom_range(0, 59) == 0) begin
                k = $urandom_range(1, 3);
                for (int r = 0; r < k; r++) cycle(1'b1, 1'($urandom));
            end
            cycle(1'b0, 1'($urandom));
        end

        cycle(1'b0, 1'b0);
        #4;
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multi-cycle control unit for the MIPS core. A Moore state machine sequences a shared-memory, single-ALU datapath through fetch, decode, execute, memory and writeback steps. It replaces the single-cycle `controller` when the datapath is rebuilt around one memory port and internal IR/A/B/ALUOut/Data registers. The unit decodes `op`/`funct` from the instruction register and drives every datapath enable and mux select each cycle.

## Interface
- No parameters; encodings are fixed in the shared package.
- `clk` — input, 1 — rising-edge clock.
- `reset` — input, 1 — synchronous, active-high; forces state FETCH.
- `op` — input, 6 — IR[31:26].
- `funct` — input, 6 — IR[5:0].
- `zero` — input, 1 — ALU zero flag, valid in the BRANCH cycle.
- `pcen` — output, 1 — PC register load enable.
- `iord` — output, 1 — memory address select: 0 = PC, 1 = ALUOut.
- `irwrite` — output, 1 — IR load enable.
- `memwrite` — output, 1 — memory write strobe.
- `regwrite` — output, 1 — register-file write enable.
- `regdst` — output, 1 — write register select: 1 = rd, 0 = rt.
- `memtoreg` — output, 1 — writeback data select: 1 = Data register, 0 = ALUOut.
- `alusrca` — output, 1 — ALU A select: 0 = PC, 1 = A register.
- `alusrcb` — output, 2 — ALU B select: 00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2.
- `pcsrc` — output, 2 — PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `alucontrol` — output, 4 — 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt.
- `state` — output, 4 — current state, for debug and the bench.

## Operation
- States and encodings:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5.
  - RTYPEEX = 6, RTYPEWB = 7, BEQ = 8, ADDIEX = 9, ADDIWB = 10, JUMP = 11.
  - BNE = 12, only with the `MC_BNE_EN` option.
- Transitions:
  - FETCH → DECODE.
  - DECODE on `op`:
    - lw 100011 and sw 101011 → MEMADR.
    - R-type 000000 → RTYPEEX.
    - beq 000100 → BEQ.
    - addi 001000 → ADDIEX.
    - j 000010 → JUMP.
    - Any other opcode → FETCH; the instruction executes as a NOP with PC already advanced.
  - MEMADR → MEMRD for lw, MEMWR for sw.
  - MEMRD → MEMWB → FETCH.
  - MEMWR, RTYPEWB, ADDIWB, BEQ, JUMP → FETCH.
  - RTYPEEX → RTYPEWB; ADDIEX → ADDIWB.
- Outputs by state. Any output not listed is 0.
  - FETCH: `irwrite`=1, `alusrcb`=01, add, `pcsrc`=00, pc-write=1.
  - DECODE: `alusrcb`=11, add (branch target into ALUOut).
  - MEMADR, ADDIEX: `alusrca`=1, `alusrcb`=10, add.
  - MEMRD, MEMWR: `iord`=1; MEMWR also `memwrite`=1.
  - MEMWB: `regwrite`=1, `memtoreg`=1.
  - RTYPEEX: `alusrca`=1, `alusrcb`=00, `alucontrol` from funct.
    - funct codes: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
    - Unknown funct gives add, but RTYPEWB is still entered (no trap).
  - RTYPEWB: `regwrite`=1, `regdst`=1. ADDIWB: `regwrite`=1, `regdst`=0.
  - BEQ: `alusrca`=1, `alusrcb`=00, sub, `pcsrc`=01, branch=1.
  - JUMP: `pcsrc`=10, pc-write=1.
- `pcen` = pc-write | (branch & `zero`) | (bne & ~`zero`).
- All outputs are pure decode of `state`. `pcen` additionally depends combinationally on `zero`.

## Timing
- Reset:
  - Outputs during and after reset equal the FETCH decode: `irwrite`=1, `pcen`=1, `alusrcb`=01, `alucontrol`=0010, all others 0, `state`=0.
  - The datapath holds PC at its reset value while `reset` is high, so these enables are harmless.
- Reset asserted mid-instruction (any state) → FETCH at the next edge. No partial writeback occurs afterwards.
- Instruction latency in cycles, FETCH to the next FETCH:
  - lw 5; sw 4; R-type 4; addi 4; beq 3; j 3.
  - Unknown opcode: 2.
- IR loads at the end of FETCH, and `op`/`funct` are stable from DECODE onward. The unit never samples `op` in FETCH.
- No handshakes: memory is combinational-read, single-cycle write.

## Configuration
- `MC_BNE_EN` defined:
  - DECODE with op 000101 → BNE.
  - BNE drives the same outputs as BEQ, with bne=1 instead of branch=1, so the branch is taken when `zero`=0. BNE → FETCH; 3 cycles.
- `MC_BNE_EN` undefined:
  - op 000101 is unknown and goes DECODE → FETCH.
  - The BNE state and bne term are absent; bne is tied to 0.

## Structure
- Package `mips_mc_pkg` holds:
  - the state enum (4-bit);
  - opcode and funct localparams;
  - `alucontrol` encodings;
  - `alusrcb`/`pcsrc` select constants.
- Sub-module `mc_aludec`: combinational (`aluop` [1:0], `funct`) → `alucontrol`.
  - aluop 00 = add, 01 = sub, 10 = use funct.
- The FSM top has one state register and one combinational next-state/output block.

## Test plan
- Reset held 3 cycles in MEMRD → `state`=0, `irwrite`=1, `pcen`=1, `regwrite`=0 on the first cycle after release; DECODE on the following cycle.
- lw (op 100011) → state sequence 0,1,2,3,4,0; `iord`=1 only in state 3; `regwrite`=`memtoreg`=1 only in state 4.
- R-type (funct 101010) → states 0,1,6,7,0; `alucontrol`=0111 in state 6; `regdst`=1, `regwrite`=1 in state 7.
- beq:
  - with `zero`=1 → `pcen`=1, `pcsrc`=01 in state 8;
  - with `zero`=0 → `pcen`=0; next state 0 in both cases.
- op 111111 → states 0,1,0; `regwrite`, `memwrite` and `pcen` (after FETCH) never asserted.
- op 000101 with `zero`=0:
  - `MC_BNE_EN` defined → state 12, `pcen`=1, `pcsrc`=01;
  - `MC_BNE_EN` undefined → DECODE → FETCH.
